pixel_fb_writer: RTL

//  Sink for the rasterizer pixel stream: accepts (x,y,color) from the line drawer, clips to screen,

---
 rtl/gfx_pkg.sv | 23 ++
 rtl/pix_fifo.sv | 59 +++++
 rtl/pixel_fb_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared constants, write-FSM state encoding and pixel record used by the
// framebuffer writer and its FIFO.
package gfx_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 32;
  localparam int COLOR_W = 16;
  localparam int ADDR_W  = 19;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_REQ  = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               last;
  } pixel_t;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO; exposes the head and the entry behind it so the
// writer can issue back-to-back requests without a bubble.
module pix_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + PTR_W'(1)];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pixel_fb_writer.sv
// Rasterizer pixel sink: clips, linearises the address, buffers and issues
// req/ack framebuffer writes; pulses frame_done once a primitive has landed.
module pixel_fb_writer
  import gfx_pkg::*;
#(
  parameter int BASE_ADDR  = 32'd0,
  parameter int FIFO_DEPTH = 32'd4
) (
  input  logic               pll_clock,
  input  logic               sys_reset_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               pix_last,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        clip_count,
  output logic [15:0]        write_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + COLOR_W;

  pixel_t             w_pix;
  logic               w_accept, w_clip, w_stage_next, w_push, w_pop;
  logic               w_empty, w_full, w_ready_next, w_drained;
  logic [CNT_W-1:0]   w_count, w_count_next;
  logic [ADDR_W-1:0]  w_addr;
  logic [ENT_W-1:0]   w_head, w_next;

  logic               r_stage_valid, r_ready, r_mem_req, r_frame_done, r_done_pending;
  logic [ADDR_W-1:0]  r_stage_x, r_stage_y, r_mem_addr;
  logic [COLOR_W-1:0] r_stage_color, r_mem_wdata;
  logic [15:0]        r_clip_count, r_write_count;
  wr_state_t          r_state;

  assign w_pix        = {pix_x, pix_y, pix_color, pix_last};
  assign w_accept     = pix_valid & r_ready;
  // Unsigned compare: negative coordinates wrap to huge values and clip too
  assign w_clip       = (w_pix.x >= COORD_W'(H_RES)) | (w_pix.y >= COORD_W'(V_RES));
  assign w_stage_next = w_accept & ~w_clip;
  assign w_addr       = ADDR_W'(BASE_ADDR) + r_stage_y * ADDR_W'(H_RES) + r_stage_x;
  assign w_pop        = r_mem_req & mem_ack & (r_state == WR_REQ);
  assign w_push       = r_stage_valid & (~w_full | w_pop);
  assign w_drained    = ~r_stage_valid & w_empty & (r_state == WR_IDLE);

  pix_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (pll_clock),
    .i_rst_n (sys_reset_n),
    .i_push  (w_push),
    .i_data  ({w_addr, r_stage_color}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready is registered from next-cycle occupancy, equal to (count + stage) < depth
  always_comb begin
    w_count_next = w_count;
    if (w_push & ~w_pop) begin
      w_count_next = w_count + CNT_W'(1);
    end else if (~w_push & w_pop) begin
      w_count_next = w_count - CNT_W'(1);
    end else begin
      w_count_next = w_count;
    end
    w_ready_next = ({1'b0, w_count_next} + {{CNT_W{1'b0}}, w_stage_next}) < (CNT_W+1)'(FIFO_DEPTH);
  end

  // Address stage, ready and clip counter
  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_stage_valid <= 1'b0;
      r_stage_x     <= '0;
      r_stage_y     <= '0;
      r_stage_color <= '0;
      r_ready       <= 1'b0;
      r_clip_count  <= 16'd0;
    end else begin
      r_stage_valid <= w_stage_next;
      r_ready       <= w_ready_next;
      if (w_stage_next) begin
        r_stage_x     <= w_pix.x[ADDR_W-1:0];
        r_stage_y     <= w_pix.y[ADDR_W-1:0];
        r_stage_color <= w_pix.color;
      end
      if (w_accept & w_clip & (r_clip_count != 16'hFFFF)) r_clip_count <= r_clip_count + 16'd1;
    end
  end

  // Write FSM: the head stays in the FIFO until acked, the next entry follows without a gap
  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state       <= WR_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_write_count <= 16'd0;
    end else begin
      case (r_state)
        WR_IDLE: begin
          if (!w_empty) begin
            r_mem_addr  <= w_head[ENT_W-1:COLOR_W];
            r_mem_wdata <= w_head[COLOR_W-1:0];
            r_mem_req   <= 1'b1;
            r_state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (w_pop) begin
            r_write_count <= r_write_count + 16'd1;
            if (w_count >= CNT_W'(2)) begin
              r_mem_addr  <= w_next[ENT_W-1:COLOR_W];
              r_mem_wdata <= w_next[COLOR_W-1:0];
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= WR_IDLE;
            end
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= WR_IDLE;
        end
      endcase
    end
  end

  // Primitive completion: a later pix_last while pending merges into one pulse
  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_frame_done   <= 1'b0;
      r_done_pending <= 1'b0;
    end else if (r_done_pending & w_drained) begin
      r_frame_done   <= 1'b1;
      r_done_pending <= w_accept & w_pix.last;
    end else begin
      r_frame_done   <= 1'b0;
      r_done_pending <= r_done_pending | (w_accept & w_pix.last);
    end
  end

  assign pix_ready   = r_ready;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy        = r_stage_valid | ~w_empty | r_mem_req;
  assign frame_done  = r_frame_done;
  assign clip_count  = r_clip_count;
  assign write_count = r_write_count;

endmodule
